// File: rtl/reg_file_pkg.sv
// Shared datapath types for the register file and ALU.
// Pure declarations: no logic, no latency.
// No flow control involved.
package reg_file_pkg;

    localparam int kDataW    = 8;
    localparam int kRegAddrW = 3;
    localparam int kNumRegs  = 1 << kRegAddrW;

    typedef logic [kDataW-1:0]    data_t;
    typedef logic [kRegAddrW-1:0] reg_addr_t;

    // ALU operation mnemonics
    typedef enum logic [2:0] {
        kADD   = 3'd0,
        kSUB   = 3'd1,
        kAND   = 3'd2,
        kOR    = 3'd3,
        kXOR   = 3'd4,
        kPASSA = 3'd5,
        kPASSB = 3'd6,
        kNOP   = 3'd7
    } ALUOp_mne;

endpackage

// File: rtl/reg_file.sv
// Register file (2 read / 1 write) with write-to-read forwarding, plus N/Z flag register.
// Reads are combinational (zero cycles); writes and flag captures land on the next CLK edge.
// No backpressure: every write/flag request presented with Reset=0 is accepted.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int W       = kDataW,
    parameter int D       = kRegAddrW,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [D-1:0] RdAddrA,
    input  logic [D-1:0] RdAddrB,
    input  logic         WrEn,
    input  logic [D-1:0] WrAddr,
    input  logic [W-1:0] WrData,
    input  logic         FlagEn,
    input  logic         N_in,
    input  logic         Z_in,
    output logic [W-1:0] DataA,
    output logic [W-1:0] DataB,
    output logic         N,
    output logic         Z
);

    localparam int NumRegs = 1 << D;

    logic [W-1:0] regs_q [NumRegs];
    logic [W-1:0] regs_d [NumRegs];
    logic         n_q;
    logic         n_d;
    logic         z_q;
    logic         z_d;
    logic         wr_allow;
    logic         fwd_ok;

    // Read port: hardwired r0 wins, then same-cycle forwarding, then storage
    function automatic logic [W-1:0] read_port(
        input logic [D-1:0] addr,
        input logic         fwd,
        input logic [D-1:0] waddr,
        input logic [W-1:0] wdata,
        input logic [W-1:0] stored
    );
        if (ZERO_R0 && (addr == '0)) begin
            return '0;
        end
        if (fwd && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    // Write gating: r0 is read-only when hardwired; reset blocks forwarding
    always_comb begin
        wr_allow = WrEn && !(ZERO_R0 && (WrAddr == '0));
        fwd_ok   = wr_allow && !Reset;
    end

    // Next-state for the register array and the flag pair
    always_comb begin
        regs_d = regs_q;
        if (wr_allow) begin
            regs_d[WrAddr] = WrData;
        end
        n_d = n_q;
        z_d = z_q;
        if (FlagEn) begin
            n_d = N_in;
            z_d = Z_in;
        end
    end

    // State update; synchronous reset overrides any write or flag capture
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            n_q    <= n_d;
            z_q    <= z_d;
        end
    end

    // Both read ports resolve independently from the same write request
    always_comb begin
        DataA = read_port(RdAddrA, fwd_ok, WrAddr, WrData, regs_q[RdAddrA]);
        DataB = read_port(RdAddrB, fwd_ok, WrAddr, WrData, regs_q[RdAddrB]);
        N     = n_q;
        Z     = z_q;
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (r0 hardwired / r0 ordinary) share one stimulus stream.
// Behavioural ALU and register model inside the bench supply every expected value.
// Directed test-plan steps followed by randomized cycles.
module tb_reg_file;
    import reg_file_pkg::*;

    logic      CLK = 1'b0;
    logic      Reset;
    reg_addr_t RdAddrA;
    reg_addr_t RdAddrB;
    logic      WrEn;
    reg_addr_t WrAddr;
    data_t     WrData;
    logic      FlagEn;
    logic      N_in;
    logic      Z_in;
    data_t     DataA1, DataB1, DataA0, DataB0;
    logic      N1, Z1, N0, Z0;

    int checks = 0;
    int errors = 0;

    // Reference state: plain arrays for each r0 flavour, shared flags
    data_t m1 [kNumRegs];
    data_t m0 [kNumRegs];
    logic  mN;
    logic  mZ;

    always #5 CLK = ~CLK;

    reg_file #(.W(kDataW), .D(kRegAddrW), .ZERO_R0(1'b1)) u_z1 (
        .CLK(CLK), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .FlagEn(FlagEn),
        .N_in(N_in), .Z_in(Z_in), .DataA(DataA1), .DataB(DataB1), .N(N1), .Z(Z1)
    );

    reg_file #(.W(kDataW), .D(kRegAddrW), .ZERO_R0(1'b0)) u_z0 (
        .CLK(CLK), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .FlagEn(FlagEn),
        .N_in(N_in), .Z_in(Z_in), .DataA(DataA0), .DataB(DataB0), .N(N0), .Z(Z0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // What a reader sees right now: hardwired r0, then pending write, then stored value
    function automatic data_t mread(input bit zr0, input reg_addr_t a);
        if (zr0 && a == 0) return 8'h00;
        if (WrEn && !Reset && !(zr0 && WrAddr == 0) && WrAddr == a) return WrData;
        return zr0 ? m1[a] : m0[a];
    endfunction

    task automatic check_now(input string tag);
        chk({tag, "_A1"}, DataA1, mread(1'b1, RdAddrA));
        chk({tag, "_B1"}, DataB1, mread(1'b1, RdAddrB));
        chk({tag, "_A0"}, DataA0, mread(1'b0, RdAddrA));
        chk({tag, "_B0"}, DataB0, mread(1'b0, RdAddrB));
        chk({tag, "_N1"}, N1, mN);
        chk({tag, "_Z1"}, Z1, mZ);
        chk({tag, "_N0"}, N0, mN);
        chk({tag, "_Z0"}, Z0, mZ);
    endtask

    // Check combinational outputs, take one edge, advance the model
    task automatic cycle(input string tag);
        #1;
        check_now(tag);
        @(posedge CLK);
        if (Reset) begin
            foreach (m1[i]) begin
                m1[i] = 8'h00;
                m0[i] = 8'h00;
            end
            mN = 1'b0;
            mZ = 1'b0;
        end else begin
            if (WrEn) begin
                if (WrAddr != 0) m1[WrAddr] = WrData;
                m0[WrAddr] = WrData;
            end
            if (FlagEn) begin
                mN = N_in;
                mZ = Z_in;
            end
        end
        #1;
    endtask

    // Behavioural ALU driving the write-back and flag inputs from stored operands
    task automatic alu_drive(input ALUOp_mne op);
        data_t a, b, r;
        a = m1[RdAddrA];
        b = m1[RdAddrB];
        case (op)
            kADD:    r = a + b;
            kSUB:    r = a - b;
            kAND:    r = a & b;
            kOR:     r = a | b;
            kXOR:    r = a ^ b;
            kPASSA:  r = a;
            kPASSB:  r = b;
            default: r = a;
        endcase
        WrData = r;
        N_in   = r[7];
        Z_in   = (r == 8'h00);
    endtask

    initial begin
        Reset = 1'b1; WrEn = 1'b0; FlagEn = 1'b0; N_in = 1'b0; Z_in = 1'b0;
        RdAddrA = '0; RdAddrB = '0; WrAddr = '0; WrData = '0;
        foreach (m1[i]) begin
            m1[i] = 8'h00;
            m0[i] = 8'h00;
        end
        mN = 1'b0;
        mZ = 1'b0;

        // Reset held two cycles, then scan every address on both ports
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        for (int a = 0; a < kNumRegs; a++) begin
            RdAddrA = reg_addr_t'(a);
            RdAddrB = reg_addr_t'(kNumRegs - 1 - a);
            @(negedge CLK);
            check_now("reset");
            chk("reset_A_const", DataA0, 8'h00);
        end

        // Write r1=0x80, r2=0x7F
        WrEn = 1'b1; WrAddr = 3'd1; WrData = 8'h80; cycle("wr_r1");
        WrAddr = 3'd2; WrData = 8'h7F; cycle("wr_r2");

        // ADD r1+r2 -> r3 with flags
        RdAddrA = 3'd1; RdAddrB = 3'd2; WrAddr = 3'd3; FlagEn = 1'b1;
        alu_drive(kADD);
        #1;
        chk("add_srcA", DataA1, 8'h80);
        chk("add_srcB", DataB1, 8'h7F);
        cycle("add");
        chk("add_N", N1, 1'b1);
        chk("add_Z", Z1, 1'b0);

        // SUB r1-r2 -> r4
        WrAddr = 3'd4;
        alu_drive(kSUB);
        cycle("sub");
        WrEn = 1'b0; FlagEn = 1'b0; RdAddrA = 3'd3; RdAddrB = 3'd4;
        #1;
        chk("r3_ff", DataA1, 8'hFF);
        chk("r4_01", DataB1, 8'h01);
        chk("sub_N", N1, 1'b0);
        chk("sub_Z", Z1, 1'b0);

        // Forwarding on both ports to r5
        WrEn = 1'b1; WrAddr = 3'd5; WrData = 8'hA5; RdAddrA = 3'd5; RdAddrB = 3'd5;
        #1;
        chk("fwd_A", DataA1, 8'hA5);
        chk("fwd_B", DataB1, 8'hA5);
        cycle("fwd");
        WrEn = 1'b0;
        #1;
        chk("fwd_hold_A", DataA1, 8'hA5);

        // r0 write: hardwired instance stays zero, ordinary instance forwards then stores
        WrEn = 1'b1; WrAddr = 3'd0; WrData = 8'h55; RdAddrA = 3'd0;
        #1;
        chk("r0_z1_pre", DataA1, 8'h00);
        chk("r0_z0_pre", DataA0, 8'h55);
        cycle("r0");
        WrEn = 1'b0;
        #1;
        chk("r0_z1_post", DataA1, 8'h00);
        chk("r0_z0_post", DataA0, 8'h55);

        // Flag-only compare: r6 == r7
        WrEn = 1'b1; WrAddr = 3'd6; WrData = 8'h80; cycle("wr_r6");
        WrAddr = 3'd7; cycle("wr_r7");
        WrEn = 1'b0; FlagEn = 1'b1; RdAddrA = 3'd6; RdAddrB = 3'd7;
        alu_drive(kSUB);
        cycle("cmp");
        chk("cmp_Z", Z1, 1'b1);
        chk("cmp_N", N1, 1'b0);
        FlagEn = 1'b0; N_in = 1'b1; Z_in = 1'b0;
        cycle("hold");
        chk("hold_Z", Z1, 1'b1);
        chk("hold_N", N1, 1'b0);

        // Reset mid-operation with a pending write and flag capture
        Reset = 1'b1; WrEn = 1'b1; WrAddr = 3'd2; WrData = 8'h33; FlagEn = 1'b1; N_in = 1'b1;
        RdAddrB = 3'd2;
        #1;
        chk("rst_nofwd_B", DataB1, 8'h7F);
        cycle("rst_mid");
        Reset = 1'b0; WrEn = 1'b0; FlagEn = 1'b0;
        #1;
        chk("rst_r2", DataB1, 8'h00);
        chk("rst_N", N1, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            Reset   = ($urandom_range(0, 19) == 0);
            WrEn    = $urandom_range(0, 1);
            FlagEn  = $urandom_range(0, 1);
            WrAddr  = reg_addr_t'($urandom_range(0, kNumRegs - 1));
            RdAddrA = reg_addr_t'($urandom_range(0, kNumRegs - 1));
            RdAddrB = ($urandom_range(0, 3) == 0) ? RdAddrA
                                                  : reg_addr_t'($urandom_range(0, kNumRegs - 1));
            WrData  = data_t'($urandom);
            N_in    = $urandom_range(0, 1);
            Z_in    = $urandom_range(0, 1);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
